i2c_arbiter: RTL and testbench

- Shares one i2c_master command interface (req/cmd/din/dout/done/slave_ack) between two requesters: port 0, the camera config sequencer, and port 1, a runtime register read/write agent.
- Ownership is granted per I2C transaction. It is held from the first granted command until a command carrying the STOP bit completes, so START…STOP sequences are never interleaved.
- Includes a hold watchdog: it forces a STOP if the owner stalls mid-transaction.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_req_slot.sv | 42 ++++
 rtl/i2c_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the two-port i2c_master arbiter.
//   CMD_*    : one-hot command bits, OR-able (e.g. START|WRITE)
//   state_t  : arbiter state encoding
//   N_PORTS  : number of requesters sharing the master
package i2c_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  localparam int N_PORTS = 2;

  typedef enum logic [2:0] {
    S_IDLE,   // no owner
    S_ISSUE,  // one-cycle command strobe to the master
    S_WAIT,   // waiting for the master to complete
    S_HOLD,   // owner keeps the bus between commands
    S_FSTOP,  // watchdog: strobe a forced STOP
    S_FWAIT   // waiting for the forced STOP to complete
  } state_t;

endpackage

// File: rtl/i2c_req_slot.sv
// Per-port pending command slot.
//   req/cmd/din : command pulse from the requester
//   clr         : owner's command has completed, free the slot
//   valid       : slot holds a command (from the cycle after req)
//   cmd_q/din_q : captured command and write byte
//   drop        : registered pulse, a req arrived while the slot was full
module i2c_req_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] cmd,
  input  logic [7:0] din,
  input  logic       clr,
  output logic       valid,
  output logic [3:0] cmd_q,
  output logic [7:0] din_q,
  output logic       drop
);

  // NOTE: cmd_q/din_q are reset as well as valid; they drive i2c_cmd/i2c_din
  // and every output is defined to read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      cmd_q <= '0;
      din_q <= '0;
      drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge value of valid, so capture and drop see the same slot state.
      drop <= req && valid;
      if (req && !valid) begin
        valid <= 1'b1;
        cmd_q <= cmd;
        din_q <= din;
      end else if (clr) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Two-port arbiter in front of a single i2c_master command interface.
// Ownership lasts from the first granted command until a command carrying
// STOP completes; a hold watchdog forces a STOP if the owner goes silent.
//   m0_* / m1_*  : requester ports (req/cmd/din in; dout/done/ack/grant out)
//   i2c_*        : command interface to the i2c_master
//   busy         : any state other than IDLE
//   lock_err     : one-cycle pulse on a forced STOP or a dropped request
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter logic [15:0] HOLD_MAX = 16'd50000,
  parameter int          HCW      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic [3:0] m0_cmd,
  input  logic [7:0] m0_din,
  output logic [7:0] m0_dout,
  output logic       m0_done,
  output logic       m0_ack,
  output logic       m0_grant,
  input  logic       m1_req,
  input  logic [3:0] m1_cmd,
  input  logic [7:0] m1_din,
  output logic [7:0] m1_dout,
  output logic       m1_done,
  output logic       m1_ack,
  output logic       m1_grant,
  output logic       i2c_req,
  output logic [3:0] i2c_cmd,
  output logic [7:0] i2c_din,
  input  logic [7:0] i2c_dout,
  input  logic       i2c_done,
  input  logic       i2c_slave_ack,
  output logic       busy,
  output logic       lock_err
);

  state_t               state, state_n;
  logic [N_PORTS-1:0]   grant;
  logic                 last;
  logic [HCW-1:0]       hold_cnt;
  logic [N_PORTS-1:0]   done_q, ack_q;
  logic [7:0]           dout_q [N_PORTS];

  logic [N_PORTS-1:0]   req_in, slot_valid, slot_drop, slot_clr;
  logic [3:0]           cmd_in   [N_PORTS];
  logic [7:0]           din_in   [N_PORTS];
  logic [3:0]           slot_cmd [N_PORTS];
  logic [7:0]           slot_din [N_PORTS];

  logic own;       // index of the current owner (grant is one-hot)
  logic win;       // arbitration winner in IDLE
  logic start;     // new grant this cycle
  logic complete;  // owner's command completed this cycle
  logic release_;  // ownership ends this cycle
  logic hold_last;

  assign req_in    = {m1_req, m0_req};
  assign cmd_in[0] = m0_cmd;
  assign cmd_in[1] = m1_cmd;
  assign din_in[0] = m0_din;
  assign din_in[1] = m1_din;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_slot
    i2c_req_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .req   (req_in[p]),
      .cmd   (cmd_in[p]),
      .din   (din_in[p]),
      .clr   (slot_clr[p]),
      .valid (slot_valid[p]),
      .cmd_q (slot_cmd[p]),
      .din_q (slot_din[p]),
      .drop  (slot_drop[p])
    );
  end

  assign own       = grant[1];
  assign slot_clr  = {N_PORTS{complete}} & grant;
  assign hold_last = (hold_cnt == HCW'(HOLD_MAX - 16'd1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n  = state;
    win      = 1'b0;
    start    = 1'b0;
    complete = 1'b0;
    release_ = 1'b0;
    case (state)
      S_IDLE: begin
        if (|slot_valid) begin
          // On a tie the port that did not own the bus last time wins.
          win     = (&slot_valid) ? ~last : slot_valid[1];
          start   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          complete = 1'b1;
          if (slot_cmd[own][3]) begin
            release_ = 1'b1;
            state_n  = S_IDLE;
          end else begin
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (slot_valid[own]) state_n = S_ISSUE;
        else if (hold_last)  state_n = S_FSTOP;
      end
      S_FSTOP: state_n = S_FWAIT;
      S_FWAIT: begin
        if (i2c_done) begin
          release_ = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      last     <= 1'b1;
      hold_cnt <= '0;
      done_q   <= '0;
      ack_q    <= '0;
      dout_q   <= '{default: '0};
    end else begin
      state <= state_n;
      if (start) begin
        grant <= win ? 2'b10 : 2'b01;
        last  <= win;
      end else if (release_) begin
        grant <= '0;
      end
      // Counter is zero on the first HOLD cycle after every entry.
      hold_cnt <= (state == S_HOLD) ? hold_cnt + HCW'(1) : '0;
      done_q   <= complete ? grant : '0;
      if (complete) begin
        dout_q[own] <= i2c_dout;
        ack_q[own]  <= i2c_slave_ack;
      end
    end
  end

  always_comb begin
    i2c_req = 1'b0;
    i2c_cmd = '0;
    i2c_din = '0;
    if (state == S_ISSUE) begin
      i2c_req = 1'b1;
      i2c_cmd = slot_cmd[own];
      i2c_din = slot_din[own];
    end else if (state == S_FSTOP) begin
      i2c_req = 1'b1;
      i2c_cmd = CMD_STOP;
    end
  end

  assign busy     = (state != S_IDLE);
  assign lock_err = (|slot_drop) || (state == S_FSTOP);

  assign m0_grant = grant[0];
  assign m1_grant = grant[1];
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_dout  = dout_q[0];
  assign m1_dout  = dout_q[1];

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m0_req = 1'b0, m1_req = 1'b0;
  logic [3:0] m0_cmd = '0, m1_cmd = '0;
  logic [7:0] m0_din = '0, m1_din = '0;
  logic [7:0] m0_dout, m1_dout;
  logic       m0_done, m1_done, m0_ack, m1_ack, m0_grant, m1_grant;
  logic       i2c_req;
  logic [3:0] i2c_cmd;
  logic [7:0] i2c_din;
  logic [7:0] i2c_dout = 8'h00;
  logic       i2c_done = 1'b0;
  logic       i2c_slave_ack = 1'b0;
  logic       busy, lock_err;

  i2c_arbiter #(.HOLD_MAX(16'd8), .HCW(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_din(m0_din), .m0_dout(m0_dout),
    .m0_done(m0_done), .m0_ack(m0_ack), .m0_grant(m0_grant),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_din(m1_din), .m1_dout(m1_dout),
    .m1_done(m1_done), .m1_ack(m1_ack), .m1_grant(m1_grant),
    .i2c_req(i2c_req), .i2c_cmd(i2c_cmd), .i2c_din(i2c_din),
    .i2c_dout(i2c_dout), .i2c_done(i2c_done), .i2c_slave_ack(i2c_slave_ack),
    .busy(busy), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks who owns the bus, whether a command is on its way / in flight,
  // and how long the owner has been quiet; expectations are for the cycle
  // that follows each clock edge.
  int         own;                 // -1: bus free
  int         last;
  bit         sending, flying, forcing;
  int         quiet;
  bit         pv [2];
  logic [3:0] pc [2];
  logic [7:0] pd [2];
  logic [3:0] s_cmd;
  logic [7:0] s_din;
  logic       e_req, e_lock, e_busy;
  logic [3:0] e_cmd;
  logic [7:0] e_din;
  logic [1:0] e_grant, e_done, e_ack;
  logic [7:0] e_dout [2];

  task automatic model_reset();
    own = -1; last = 1; sending = 0; flying = 0; forcing = 0; quiet = 0;
    for (int p = 0; p < 2; p++) begin pv[p] = 0; pc[p] = '0; pd[p] = '0; e_dout[p] = '0; end
    s_cmd = '0; s_din = '0;
    e_req = 0; e_lock = 0; e_busy = 0; e_cmd = '0; e_din = '0;
    e_grant = '0; e_done = '0; e_ack = '0;
  endtask

  task automatic model_step();
    bit         rq [2];
    bit         old_v [2];
    logic [3:0] c [2];
    logic [7:0] d [2];
    rq[0] = m0_req; rq[1] = m1_req; c[0] = m0_cmd; c[1] = m1_cmd; d[0] = m0_din; d[1] = m1_din;
    if (rst) begin model_reset(); return; end
    old_v = pv;
    e_done = '0;
    e_lock = 0;
    for (int p = 0; p < 2; p++) if (rq[p] && old_v[p]) e_lock = 1;
    if (sending) begin
      sending = 0;
      flying  = 1;
    end else if (flying) begin
      if (i2c_done) begin
        flying = 0;
        if (forcing) begin
          forcing = 0;
          own = -1;
        end else begin
          e_done[own] = 1'b1;
          e_dout[own] = i2c_dout;
          e_ack[own]  = i2c_slave_ack;
          pv[own]     = 0;
          if (pc[own][3]) own = -1;
          else quiet = 0;
        end
      end
    end else if (own < 0) begin
      if (old_v[0] || old_v[1]) begin
        own = (old_v[0] && old_v[1]) ? 1 - last : (old_v[1] ? 1 : 0);
        last = own;
        sending = 1; s_cmd = pc[own]; s_din = pd[own];
      end
    end else begin
      if (old_v[own]) begin
        sending = 1; s_cmd = pc[own]; s_din = pd[own];
      end else if (quiet == HOLD_MAX - 1) begin
        sending = 1; forcing = 1; s_cmd = 4'b1000; s_din = 8'h00; e_lock = 1;
      end else begin
        quiet++;
      end
    end
    for (int p = 0; p < 2; p++)
      if (rq[p] && !old_v[p]) begin pv[p] = 1; pc[p] = c[p]; pd[p] = d[p]; end
    e_req   = sending;
    e_cmd   = sending ? s_cmd : 4'h0;
    e_din   = sending ? s_din : 8'h00;
    e_grant = (own < 0) ? 2'b00 : 2'(1 << own);
    e_busy  = (own >= 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
    end
  end

  // ---------------- event log for hand-computed checks ----------------
  int         ireq_t[$], d0_t[$], d1_t[$], lk_t[$], gf0_t[$];
  logic [3:0] ireq_c[$];
  logic [1:0] ireq_g[$];
  logic       prev_g0 = 1'b0;

  task automatic clear_log();
    ireq_t.delete(); ireq_c.delete(); ireq_g.delete();
    d0_t.delete(); d1_t.delete(); lk_t.delete(); gf0_t.delete();
  endtask

  // Single compare process: every cycle, DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      check("i2c_req",  i2c_req,  e_req);
      check("i2c_cmd",  i2c_cmd,  e_cmd);
      check("i2c_din",  i2c_din,  e_din);
      check("grant",    {m1_grant, m0_grant}, e_grant);
      check("done",     {m1_done, m0_done},   e_done);
      check("busy",     busy,     e_busy);
      check("lock_err", lock_err, e_lock);
      check("m0_dout",  m0_dout,  e_dout[0]);
      check("m1_dout",  m1_dout,  e_dout[1]);
      if (e_done[0]) check("m0_ack", m0_ack, e_ack[0]);
      if (e_done[1]) check("m1_ack", m1_ack, e_ack[1]);
      if (i2c_req) begin ireq_t.push_back(cyc); ireq_c.push_back(i2c_cmd); ireq_g.push_back({m1_grant, m0_grant}); end
      if (m0_done) d0_t.push_back(cyc);
      if (m1_done) d1_t.push_back(cyc);
      if (lock_err) lk_t.push_back(cyc);
      if (prev_g0 && !m0_grant) gf0_t.push_back(cyc);
      prev_g0 = m0_grant;
    end
  end

  // ---------------- i2c_master stand-in ----------------
  // Completes each command 3 cycles after its strobe.
  logic [7:0] resp_dout = 8'h3C;
  logic       resp_ack  = 1'b1;

  initial forever begin
    @(negedge clk);
    if (i2c_req === 1'b1) begin
      repeat (3) @(posedge clk);
      #1;
      i2c_done = 1'b1; i2c_dout = resp_dout; i2c_slave_ack = resp_ack;
      @(posedge clk);
      #1;
      i2c_done = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int p, input logic [3:0] c, input logic [7:0] d);
    if (p == 0) begin m0_req = 1'b1; m0_cmd = c; m0_din = d; end
    else        begin m1_req = 1'b1; m1_cmd = c; m1_din = d; end
    tick(1);
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic pulse_both(input logic [3:0] c0, input logic [7:0] d0,
                            input logic [3:0] c1, input logic [7:0] d1);
    m0_req = 1'b1; m0_cmd = c0; m0_din = d0;
    m1_req = 1'b1; m1_cmd = c1; m1_din = d1;
    tick(1);
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic wait_done(input int p, input int budget, input string nm);
    int k = 0;
    while (k < budget && !(p == 0 ? m0_done : m1_done)) begin tick(1); k++; end
    check(nm, k < budget, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
  endtask

  int t0, t1, t2, dd;

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    tick(3);
    rst = 1'b0;

    // Single owner: three-command transaction on port 0.
    clear_log();
    t0 = cyc; pulse(0, 4'b0011, 8'h78); wait_done(0, 30, "t1_done0");
    t1 = cyc; pulse(0, 4'b0010, 8'h30); wait_done(0, 30, "t1_done1");
    t2 = cyc; pulse(0, 4'b1010, 8'h08); wait_done(0, 30, "t1_done2");
    tick(2);
    check("t1_nreq",  ireq_t.size(), 3);
    check("t1_lat0",  ireq_t[0], t0 + 2);
    check("t1_lat1",  ireq_t[1], t1 + 2);
    check("t1_lat2",  ireq_t[2], t2 + 2);
    check("t1_cmd0",  ireq_c[0], 4'b0011);
    check("t1_cmd2",  ireq_c[2], 4'b1010);
    check("t1_done",  d0_t[2],   t2 + 6);
    check("t1_gfall", gf0_t[0],  t2 + 6);

    // Contention straight after reset: port 0 first, port 1 after its STOP.
    do_reset();
    clear_log();
    t0 = cyc; pulse_both(4'b1011, 8'h11, 4'b1011, 8'h22);
    tick(20);
    check("t2_g0",   ireq_g[0], 2'b01);
    check("t2_t0",   ireq_t[0], t0 + 2);
    check("t2_g1",   ireq_g[1], 2'b10);
    check("t2_t1",   ireq_t[1], t0 + 7);
    // Port 0 alone, then another tie: port 1 now wins.
    pulse(0, 4'b1011, 8'h33);
    tick(12);
    clear_log();
    pulse_both(4'b1011, 8'h44, 4'b1011, 8'h55);
    tick(20);
    check("t2_tie2a", ireq_g[0], 2'b10);
    check("t2_tie2b", ireq_g[1], 2'b01);

    // No interleave + read path: port 1 queued while port 0 holds.
    clear_log();
    resp_dout = 8'hA5; resp_ack = 1'b1;
    pulse(0, 4'b0011, 8'h50); wait_done(0, 30, "t3_done0");
    pulse(1, 4'b1100, 8'h00);
    pulse(0, 4'b1010, 8'h51);
    wait_done(1, 40, "t3_done1");
    check("t3_m1_dout", m1_dout, 8'hA5);
    check("t3_m1_ack",  m1_ack,  1'b1);
    tick(2);
    check("t3_nreq",  ireq_t.size(), 3);
    check("t3_g1st",  ireq_g[1], 2'b01);
    check("t3_p1g",   ireq_g[2], 2'b10);
    check("t3_p1t",   ireq_t[2], d0_t[1] + 1);
    check("t3_p1cmd", ireq_c[2], 4'b1100);

    // Watchdog: owner goes silent in HOLD.
    clear_log();
    resp_ack = 1'b0;
    pulse(0, 4'b0011, 8'h60); wait_done(0, 30, "t4_done0");
    dd = cyc;
    tick(20);
    check("t4_ftime", ireq_t[1], dd + 8);
    check("t4_fcmd",  ireq_c[1], 4'b1000);
    check("t4_nlock", lk_t.size(), 1);
    check("t4_lock",  lk_t[0], dd + 8);
    check("t4_ndone", d0_t.size(), 1);
    check("t4_gfall", gf0_t[0], dd + 12);

    // Dropped request: second pulse while the slot is still valid.
    clear_log();
    t0 = cyc; pulse(0, 4'b1011, 8'h70); pulse(0, 4'b1100, 8'h71);
    tick(12);
    check("t5_nlock", lk_t.size(), 1);
    check("t5_lock",  lk_t[0], t0 + 2);
    check("t5_nreq",  ireq_t.size(), 1);
    check("t5_cmd",   ireq_c[0], 4'b1011);

    // Reset while waiting for completion.
    clear_log();
    pulse(1, 4'b1011, 8'h80);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_grant", {m1_grant, m0_grant}, 2'b00);
    check("t6_busy",  busy,    1'b0);
    check("t6_ireq",  i2c_req, 1'b0);
    check("t6_dout1", m1_dout, 8'h00);
    check("t6_lock",  lock_err, 1'b0);
    tick(8);
    check("t6_nodone", d1_t.size(), 0);
    check("t6_nreq",   ireq_t.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
